// File: rtl/pcu_fsm.sv
// Program-counter unit: sequences fetch requests, computes the next PC from
// execute-stage controls, raises misaligned-target traps and counts retired instructions.
module pcu_fsm #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              IALIGN   = 4,
    parameter int              CNT_W    = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_pc_valid,
    input  logic             i_pc_ready,
    input  logic             i_ex_valid,
    input  logic             i_brch,
    input  logic             i_jal,
    input  logic             i_jalr,
    input  logic             i_zero,
    input  logic             i_ecall,
    input  logic             i_mret,
    input  logic             i_ebreak,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_mtvec,
    input  logic [XLEN-1:0]  i_mepc,
    output logic             o_misalign,
    output logic [XLEN-1:0]  o_bad_addr,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_EX = 3'd2,
        S_TRAP    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [XLEN-1:0]  ALIGN_MASK = (IALIGN == 4) ? XLEN'(2'b11) : XLEN'(2'b01);
    localparam logic [XLEN-1:0]  MTVEC_MASK = ~XLEN'(2'b11);
    localparam logic [XLEN-1:0]  JALR_MASK  = ~XLEN'(1'b1);
    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(3'd4);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);

    state_t            state_q, state_d;
    logic [1:0]        rel_q, rel_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   bad_addr_q, bad_addr_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [XLEN-1:0]   jalr_tgt_s, rel_tgt_s, jump_tgt_s, mtvec_al_s;
    logic              jump_mis_s, taken_s;

    // Jump/branch target and alignment computation
    always_comb begin
        jalr_tgt_s = (i_rs1 + i_imm) & JALR_MASK;
        rel_tgt_s  = pc_q + i_imm;
        jump_tgt_s = i_jalr ? jalr_tgt_s : rel_tgt_s;
        jump_mis_s = |(jump_tgt_s & ALIGN_MASK);
        mtvec_al_s = i_mtvec & MTVEC_MASK;
        taken_s    = i_jalr | i_jal | (i_brch & ~i_zero);
    end

    // Next-state, next-PC and output computation
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        retired_d  = retired_q;
        // Two-stage release shifter keeps BOOT until reset removal is clean
        rel_d      = {rel_q[0], 1'b1};
        case (state_q)
            S_BOOT: begin
                if (rel_q[1]) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_BOOT;
                end
            end
            S_ISSUE: begin
                if (i_pc_ready) begin
                    state_d = S_WAIT_EX;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT_EX: begin
                if (i_ex_valid) begin
                    retired_d = retired_q + CNT_ONE;
                    state_d   = S_ISSUE;
                    if (i_ebreak) begin
                        state_d = S_HALT;
                    end else if (i_ecall) begin
                        pc_d = mtvec_al_s;
                    end else if (i_mret) begin
                        pc_d = i_mepc;
                    end else if (taken_s) begin
                        if (jump_mis_s) begin
                            state_d    = S_TRAP;
                            misalign_d = 1'b1;
                            bad_addr_d = jump_tgt_s;
                        end else begin
                            pc_d = jump_tgt_s;
                        end
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else begin
                    state_d = S_WAIT_EX;
                end
            end
            S_TRAP: begin
                pc_d    = mtvec_al_s;
                state_d = S_ISSUE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
        pc_valid_d = (state_d == S_ISSUE);
        halted_d   = (state_d == S_HALT);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_BOOT;
            rel_q      <= 2'b00;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
            halted_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            rel_q      <= rel_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
            halted_q   <= halted_d;
            retired_q  <= retired_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_valid = pc_valid_q;
    assign o_misalign = misalign_q;
    assign o_bad_addr = bad_addr_q;
    assign o_halted   = halted_q;
    assign o_retired  = retired_q;

endmodule
